// File: rtl/sbox_engine.sv
// sbox_engine: sequential AES (Inv)SubBytes over LANES bytes per request.
// Each lane computes x^254 in GF(2^8) with one shared square-multiply step per
// cycle (7 cycles), then applies the affine transform.
// Optional feature macro: SBOX_INV_EN (honour in_mode, adds the InvSubBytes path).
module sbox_engine #(
  parameter int unsigned LANES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [LANES*8-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] out_data
);

  typedef enum logic [1:0] {StIdle, StExp, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [2:0]         r_step;
  logic [7:0]         r_x [LANES];
  logic [7:0]         r_r [LANES];
  logic [LANES*8-1:0] r_out_data;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_last_step;
  logic               w_in_mode;
  logic               w_mode;
  logic [7:0]         w_cap    [LANES];
  logic [7:0]         w_r_next [LANES];
  logic [LANES*8-1:0] w_out_next;

  // GF(2^8) multiply modulo 0x11B, 8-bit result.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gsq(input logic [7:0] a);
    return gmul(a, a);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic r_mode;
  assign w_in_mode = in_mode;
  assign w_mode    = r_mode;

  // Mode bit captured with the request so later in_mode changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_mode <= 1'b0;
    else if (w_accept) r_mode <= in_mode;
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = in_mode;
  assign w_in_mode     = 1'b0;
  assign w_mode        = 1'b0;
`endif

  assign w_accept    = in_valid && in_ready;
  assign w_last_step = (r_state == StExp) && (r_step == 3'd6);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM next state and in_ready; no accept while a result is pending.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StExp;
      end
      StExp:   if (w_last_step) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Step counter: 0..5 square-multiply, 6 final square.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_step <= 3'd0;
    else if (w_accept)          r_step <= 3'd0;
    else if (r_state == StExp)  r_step <= w_last_step ? 3'd0 : r_step + 3'd1;
  end

  // Per-lane capture, exponentiation step and output mapping.
  always_comb begin
    w_out_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_cap[i] = in_data[8*i +: 8];
`ifdef SBOX_INV_EN
      if (w_in_mode) w_cap[i] = inv_affine(in_data[8*i +: 8]);
`endif
      w_r_next[i] = (r_step == 3'd6) ? gsq(r_r[i]) : gmul(gsq(r_r[i]), r_x[i]);
      w_out_next[8*i +: 8] = w_mode ? w_r_next[i] : affine(w_r_next[i]);
    end
  end

  // Lane operand/accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        r_x[i] <= 8'h00;
        r_r[i] <= 8'h00;
      end
    end else if (w_accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        r_x[i] <= w_cap[i];
        r_r[i] <= w_cap[i];
      end
    end else if (r_state == StExp) begin
      for (int unsigned i = 0; i < LANES; i++) r_r[i] <= w_r_next[i];
    end
  end

  // Output register: loads on the final step and holds until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_last_step) begin
      r_out_data  <= w_out_next;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
